// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free ratio shadowing, tick and bypass outputs.
// Optional CLK_DIV_DUTY50_EN adds a negedge stretch flop for exact 50% duty on odd ratios.
module clk_div_prog #(
  parameter int DIV_W = 8
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic [DIV_W-1:0] i_div_ratio,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_bypass,
  output logic [DIV_W-1:0] o_ratio_act
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_act;
  logic             r_gen;
  logic             r_start;
  logic             r_tick;

  logic             w_div_mode;
  logic             w_wrap;
  logic             w_gen_out;
  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_cnt_inc;
  logic [DIV_W-1:0] w_last;

  assign w_div_mode = i_clk_en && (r_act >= TWO);
  assign w_half     = r_act >> 1;
  assign w_cnt_inc  = r_cnt + ONE;
  assign w_last     = r_act - ONE;
  // r_start forces an immediate rising edge on the first cycle of divide mode.
  assign w_wrap     = r_start || (r_cnt == w_last);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_act   <= '0;
      r_gen   <= 1'b0;
      r_start <= 1'b1;
      r_tick  <= 1'b0;
    end else if (!w_div_mode) begin
      if (i_clk_en) begin
        r_act <= i_div_ratio;
      end
      r_cnt   <= '0;
      r_gen   <= 1'b0;
      r_start <= 1'b1;
      r_tick  <= 1'b1;
    end else if (w_wrap) begin
      // The new ratio is only sampled here, so a period is never cut short.
      r_cnt   <= '0;
      r_gen   <= 1'b1;
      r_start <= 1'b0;
      r_tick  <= 1'b1;
      r_act   <= i_div_ratio;
    end else begin
      r_cnt   <= w_cnt_inc;
      r_gen   <= (w_cnt_inc < w_half);
      r_tick  <= 1'b0;
    end
  end

`ifdef CLK_DIV_DUTY50_EN
  logic r_gen_n;

  // Half-cycle delayed copy stretches the high phase of odd ratios by half a reference period.
  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gen_n <= 1'b0;
    end else begin
      r_gen_n <= r_gen;
    end
  end

  assign w_gen_out = r_act[0] ? (r_gen | r_gen_n) : r_gen;
`else
  assign w_gen_out = r_gen;
`endif

  assign o_bypass    = !w_div_mode;
  assign o_div_clk   = w_div_mode ? w_gen_out : i_ref_clk;
  assign o_tick      = r_tick;
  assign o_ratio_act = r_act;

endmodule
